alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//   Upstream issue stage and downstream capture stage for the 8-bit/16-command combinational ALU.
//   - Accepts operations {a, b, cmd} over a valid/ready handshake.
//   - Registers them onto the ALU operand ports and asserts the ALU output enable.
//   - Waits a fixed settle time, then captures the ALU's 16-bit result into a show-ahead result FIFO.
//   - The consumer drains results over a second valid/ready handshake.
// PARAMETERS
//   DEPTH       4  result FIFO entries; power of two, >= 2
//   SETTLE_CYC  1  cycles ALU inputs are held before capture; >= 1
// PORTS
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   op_valid   in   1   operation request valid
//   op_ready   out  1   sequencer can accept an operation this cycle
//   op_a       in   8   operand A
//   op_b       in   8   operand B
//   op_cmd     in   4   ALU command (0=ADD ... 5=DIV ... 15=BUF)
//   alu_a      out  8   to ALU a_in
//   alu_b      out  8   to ALU b_in
//   alu_cmd    out  4   to ALU command_in
//   alu_oe     out  1   to ALU oe
//   alu_d      in   16  from ALU d_out
//   res_valid  out  1   FIFO head valid (FIFO not empty)
//   res_ready  in   1   consumer takes head this cycle
//   res_data   out  16  head result
//   res_cmd    out  4   command that produced the head result
//   res_err    out  1   head result is divide-by-zero
//   op_count   out  16  completed (captured) operations; wraps at 16'hFFFF -> 0
// BEHAVIOUR
//   Reset (rst_n low, async):
//     - state IDLE; FIFO empty, pointers 0; settle counter 0; op_count 0.
//     - All outputs 0; op_ready rises in the first cycle after release.
//   Reset mid-operation discards the in-flight op and all FIFO contents.
//   FSM IDLE -> WAIT -> IDLE:
//     - IDLE: op_ready = (fifo_count < DEPTH). alu_oe = 0; alu_a/alu_b/alu_cmd hold their last values.
//     - Accept on op_valid && op_ready at edge k: latch op_a/op_b/op_cmd into alu_a/alu_b/alu_cmd.
//       alu_oe = 1 from edge k. Settle counter loads SETTLE_CYC-1. Go to WAIT.
//     - WAIT: op_ready = 0; counter decrements each edge.
//     - Capture edge: when the counter is 0, i.e. edge k+SETTLE_CYC, push {alu_cmd, err, data},
//       increment op_count, drop alu_oe to 0, go to IDLE.
//     - Throughput: one op per SETTLE_CYC+1 cycles.
//     - Latency: accept edge to res_valid (FIFO previously empty) is SETTLE_CYC cycles.
//   Divide-by-zero: alu_cmd == 4'b0101 and alu_b == 0 -> push data 16'h0000 with err = 1;
//     alu_d is ignored. Otherwise data = alu_d and err = 0.
//   FIFO:
//     - Show-ahead: res_data/res_cmd/res_err present the head combinationally from storage.
//       They are 0 when the FIFO is empty.
//     - Pop on res_valid && res_ready. Read and write pointers wrap modulo DEPTH.
//     - Push and pop in the same edge: count unchanged; both pointers advance.
//     - Overflow is impossible: acceptance requires count < DEPTH and only one op is in flight.
//       A pop while in WAIT only frees space.
//     - res_ready while empty: no effect.
//   op_valid while op_ready = 0: ignored; the requester must hold the op until accepted.
// TESTING
//   Reset, then ADD a=25 b=17 -> op_ready low 1 cycle, res_valid 1 cycle after accept;
//     res_data=16'd42, res_cmd=0, res_err=0, op_count=1.
//   MUL a=15 b=15, then DIV a=200 b=0, res_ready=1 -> res_data 16'd225 (err 0),
//     then 16'h0000 with err=1.
//   res_ready held 0, issue 5 ops (DEPTH=4) -> op_ready stays low after the 4th capture.
//     One pop re-enables accept. Heads come out in issue order.
//   Full FIFO with op in WAIT and simultaneous pop at the capture edge -> count unchanged.
//     Pointers wrap with no lost or duplicated entry.
//   rst_n pulsed low mid-WAIT with 2 entries queued -> res_valid=0, alu_oe=0, op_count=0
//     immediately; the next op starts cleanly.
//   SETTLE_CYC=3: accept-to-capture distance is exactly 3 edges. alu_oe is high for exactly
//     3 cycles per op.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issues {a,b,cmd} to a combinational ALU, holds it SETTLE_CYC cycles, captures into a show-ahead FIFO.
// Accept-to-result latency SETTLE_CYC cycles; op_ready drops while an op is in flight or the FIFO is full.
module alu_op_sequencer #(
    parameter int DEPTH      = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic [3:0]  op_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_cmd,
    output logic        alu_oe,
    input  logic [15:0] alu_d,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [3:0]  res_cmd,
    output logic        res_err,
    output logic [15:0] op_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic        err;
        logic [15:0] data;
    } res_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    res_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_next;
    logic            accept;
    logic            capture;
    logic            pop;
    logic            div_zero;
    res_t            push_entry;
    res_t            head;

    assign accept     = op_valid && op_ready;
    assign capture    = (state == WAIT) && (settle_cnt == '0);
    assign pop        = res_valid && res_ready;
    assign count_next = fifo_count + CW'(capture) - CW'(pop);

    // A divide by zero is flagged here; the ALU's own output for that case is not trusted.
    assign div_zero   = (alu_cmd == 4'b0101) && (alu_b == 8'd0);
    assign push_entry = '{cmd: alu_cmd, err: div_zero, data: (div_zero ? 16'h0000 : alu_d)};

    assign res_valid  = (fifo_count != '0);
    assign head       = mem[rd_ptr];
    assign res_data   = res_valid ? head.data : 16'h0000;
    assign res_cmd    = res_valid ? head.cmd  : 4'h0;
    assign res_err    = res_valid ? head.err  : 1'b0;

    // op_ready is registered from next-cycle state so it stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_ready   <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_cmd    <= 4'h0;
            alu_oe     <= 1'b0;
            settle_cnt <= '0;
            op_count   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= op_a;
                        alu_b      <= op_b;
                        alu_cmd    <= op_cmd;
                        alu_oe     <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        op_ready   <= 1'b0;
                        state      <= WAIT;
                    end else begin
                        op_ready   <= (count_next < FULL_CNT);
                    end
                end
                WAIT: begin
                    if (settle_cnt == '0) begin
                        op_count <= op_count + 16'd1;
                        alu_oe   <= 1'b0;
                        op_ready <= (count_next < FULL_CNT);
                        state    <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                        op_ready   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b0;
                    alu_oe   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (capture) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_next;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at SETTLE_CYC=1, one at SETTLE_CYC=3.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        op_valid, op_ready;
    logic [7:0]  op_a, op_b;
    logic [3:0]  op_cmd;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_oe;
    logic [15:0] alu_d;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_cmd;
    logic        res_err;
    logic [15:0] op_count;

    logic        s3_op_valid, s3_op_ready;
    logic [7:0]  s3_op_a, s3_op_b;
    logic [3:0]  s3_op_cmd;
    logic [7:0]  s3_alu_a, s3_alu_b;
    logic [3:0]  s3_alu_cmd;
    logic        s3_alu_oe;
    logic [15:0] s3_alu_d;
    logic        s3_res_valid, s3_res_ready;
    logic [15:0] s3_res_data;
    logic [3:0]  s3_res_cmd;
    logic        s3_res_err;
    logic [15:0] s3_op_count;

    int pass_cnt;
    int total_cnt;

    // Reference ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 15 BUF, else XOR.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        case (c)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a & b};
            4'd3:    return {8'h00, a | b};
            4'd4:    return {8'h00, a} * {8'h00, b};
            4'd5:    return (b == 8'd0) ? 16'hFFFF : {8'h00, a / b};
            4'd15:   return {8'h00, a};
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    assign alu_d    = alu_f(alu_a, alu_b, alu_cmd);
    assign s3_alu_d = alu_f(s3_alu_a, s3_alu_b, s3_alu_cmd);

    alu_op_sequencer #(.DEPTH(4), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_cmd(op_cmd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe), .alu_d(alu_d),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cmd(res_cmd), .res_err(res_err),
        .op_count(op_count)
    );

    alu_op_sequencer #(.DEPTH(4), .SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .op_valid(s3_op_valid), .op_ready(s3_op_ready),
        .op_a(s3_op_a), .op_b(s3_op_b), .op_cmd(s3_op_cmd),
        .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_cmd(s3_alu_cmd), .alu_oe(s3_alu_oe), .alu_d(s3_alu_d),
        .res_valid(s3_res_valid), .res_ready(s3_res_ready),
        .res_data(s3_res_data), .res_cmd(s3_res_cmd), .res_err(s3_res_err),
        .op_count(s3_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op at a negedge, waits for op_ready, returns at the negedge after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] cmd);
        int waited;
        waited   = 0;
        op_a     = a;
        op_b     = b;
        op_cmd   = cmd;
        op_valid = 1'b1;
        while (!op_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!op_ready) begin
            total_cnt++;
            $display("FAIL issue_timeout: op_ready=%0b required 1 within 50 cycles", op_ready);
            op_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            op_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (op_ready !== 1'b0) $display("FAIL rst_op_ready: got %0b want 0", op_ready); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %0b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (alu_oe !== 1'b0) $display("FAIL rst_alu_oe: got %0b want 0", alu_oe); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd0) $display("FAIL rst_op_count: got %0d want 0", op_count); else pass_cnt++;
        total_cnt++; if (res_data !== 16'd0) $display("FAIL rst_res_data: got %h want 0000", res_data); else pass_cnt++;
        total_cnt++; if (alu_a !== 8'd0) $display("FAIL rst_alu_a: got %h want 00", alu_a); else pass_cnt++;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (op_ready !== 1'b0) $display("FAIL rst_release_ready: got %0b want 0", op_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (op_ready !== 1'b1) $display("FAIL rst_ready_rise: got %0b want 1", op_ready); else pass_cnt++;
        total_cnt++; if (s3_op_ready !== 1'b1) $display("FAIL rst_s3_ready_rise: got %0b want 1", s3_op_ready); else pass_cnt++;
    endtask

    task automatic test_add();
        issue(8'd25, 8'd17, 4'd0);
        total_cnt++; if (op_ready !== 1'b0) $display("FAIL add_ready_low: got %0b want 0", op_ready); else pass_cnt++;
        total_cnt++; if (alu_oe !== 1'b1) $display("FAIL add_oe_high: got %0b want 1", alu_oe); else pass_cnt++;
        total_cnt++; if (alu_a !== 8'd25 || alu_b !== 8'd17 || alu_cmd !== 4'd0)
            $display("FAIL add_alu_ports: got a=%0d b=%0d cmd=%0d want 25 17 0", alu_a, alu_b, alu_cmd); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL add_not_yet_valid: got %0b want 0", res_valid); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (res_valid !== 1'b1) $display("FAIL add_res_valid: got %0b want 1", res_valid); else pass_cnt++;
        total_cnt++; if (res_data !== 16'd42) $display("FAIL add_res_data: got %0d want 42", res_data); else pass_cnt++;
        total_cnt++; if (res_cmd !== 4'd0 || res_err !== 1'b0)
            $display("FAIL add_res_cmd_err: got cmd=%0d err=%0b want 0 0", res_cmd, res_err); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd1) $display("FAIL add_op_count: got %0d want 1", op_count); else pass_cnt++;
        total_cnt++; if (op_ready !== 1'b1 || alu_oe !== 1'b0)
            $display("FAIL add_back_idle: got ready=%0b oe=%0b want 1 0", op_ready, alu_oe); else pass_cnt++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total_cnt++; if (res_valid !== 1'b0 || res_data !== 16'd0)
            $display("FAIL add_drained: got valid=%0b data=%h want 0 0000", res_valid, res_data); else pass_cnt++;
    endtask

    task automatic test_mul_div();
        res_ready = 1'b1;
        issue(8'd15, 8'd15, 4'd4);
        @(negedge clk);
        total_cnt++; if (res_valid !== 1'b1 || res_data !== 16'd225 || res_err !== 1'b0 || res_cmd !== 4'd4)
            $display("FAIL mul_result: got v=%0b d=%0d err=%0b cmd=%0d want 1 225 0 4", res_valid, res_data, res_err, res_cmd); else pass_cnt++;
        issue(8'd200, 8'd0, 4'd5);
        total_cnt++; if (res_valid !== 1'b0 || alu_oe !== 1'b1)
            $display("FAIL div_wait: got valid=%0b oe=%0b want 0 1", res_valid, alu_oe); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_err !== 1'b1 || res_cmd !== 4'd5)
            $display("FAIL div_zero_result: got v=%0b d=%h err=%0b cmd=%0d want 1 0000 1 5", res_valid, res_data, res_err, res_cmd); else pass_cnt++;
        @(negedge clk);
        res_ready = 1'b0;
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL div_popped: got %0b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd3) $display("FAIL muldiv_op_count: got %0d want 3", op_count); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [15:0] exp_q [4];
        res_ready = 1'b0;
        issue(8'd1, 8'd1, 4'd0);
        issue(8'd2, 8'd3, 4'd0);
        issue(8'd10, 8'd3, 4'd1);
        issue(8'd6, 8'd7, 4'd4);
        @(negedge clk);
        total_cnt++; if (op_ready !== 1'b0) $display("FAIL full_ready_low: got %0b want 0", op_ready); else pass_cnt++;
        total_cnt++; if (res_valid !== 1'b1 || res_data !== 16'd2)
            $display("FAIL full_head: got v=%0b d=%0d want 1 2", res_valid, res_data); else pass_cnt++;
        op_a = 8'd9; op_b = 8'd9; op_cmd = 4'd0; op_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++; if (op_ready !== 1'b0 || alu_oe !== 1'b0)
                $display("FAIL full_blocked_%0d: got ready=%0b oe=%0b want 0 0", i, op_ready, alu_oe); else pass_cnt++;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total_cnt++; if (op_ready !== 1'b1 || res_data !== 16'd5)
            $display("FAIL full_pop_reenable: got ready=%0b head=%0d want 1 5", op_ready, res_data); else pass_cnt++;
        @(negedge clk);
        op_valid = 1'b0;
        total_cnt++; if (alu_oe !== 1'b1 || alu_a !== 8'd9)
            $display("FAIL full_fifth_accept: got oe=%0b a=%0d want 1 9", alu_oe, alu_a); else pass_cnt++;
        @(negedge clk);
        exp_q[0] = 16'd5; exp_q[1] = 16'd7; exp_q[2] = 16'd42; exp_q[3] = 16'd18;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (res_valid !== 1'b1 || res_data !== exp_q[i])
                $display("FAIL full_order_%0d: got v=%0b d=%0d want 1 %0d", i, res_valid, res_data, exp_q[i]); else pass_cnt++;
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL full_empty: got %0b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd8) $display("FAIL full_op_count: got %0d want 8", op_count); else pass_cnt++;
    endtask

    task automatic test_wrap_simul();
        logic [15:0] exp_q [3];
        res_ready = 1'b0;
        issue(8'd3, 8'd4, 4'd0);
        issue(8'd50, 8'd5, 4'd5);
        issue(8'hFF, 8'd1, 4'd0);
        issue(8'd200, 8'd100, 4'd1);
        total_cnt++; if (res_data !== 16'd7) $display("FAIL wrap_head_a: got %0d want 7", res_data); else pass_cnt++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        total_cnt++; if (res_valid !== 1'b1 || res_data !== 16'd10 || op_ready !== 1'b1)
            $display("FAIL wrap_simul_d: got v=%0b d=%0d ready=%0b want 1 10 1", res_valid, res_data, op_ready); else pass_cnt++;
        issue(8'h12, 8'h00, 4'd15);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_q[0] = 16'd256; exp_q[1] = 16'd100; exp_q[2] = 16'h0012;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (res_valid !== 1'b1 || res_data !== exp_q[i])
                $display("FAIL wrap_order_%0d: got v=%0b d=%h want 1 %h", i, res_valid, res_data, exp_q[i]); else pass_cnt++;
            if (i == 2) begin
                total_cnt++; if (res_cmd !== 4'd15) $display("FAIL wrap_buf_cmd: got %0d want 15", res_cmd); else pass_cnt++;
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        total_cnt++; if (res_valid !== 1'b0) $display("FAIL wrap_empty: got %0b want 0", res_valid); else pass_cnt++;
        total_cnt++; if (op_count !== 16'd13) $display("FAIL wrap_op_count: got %0d want 13", op_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        issue(8'd1, 8'd2, 4'd0);
        issue(8'd3, 8'd4, 4'd0);
        issue(8'd5, 8'd6, 4'd4);
        total_cnt++; if (alu_oe !== 1'b1 || res_valid !== 1'b1)
            $display("FAIL mid_pre: got oe=%0b v=%0b want 1 1", alu_oe, res_valid); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (res_valid !== 1'b0 || alu_oe !== 1'b0 || op_count !== 16'd0)
            $display("FAIL mid_reset: got v=%0b oe=%0b cnt=%0d want 0 0 0", res_valid, alu_oe, op_count); else pass_cnt++;
        total_cnt++; if (op_ready !== 1'b0 || res_data !== 16'd0)
            $display("FAIL mid_reset_ready: got ready=%0b d=%h want 0 0000", op_ready, res_data); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (op_ready !== 1'b1 || res_valid !== 1'b0)
            $display("FAIL mid_restart: got ready=%0b v=%0b want 1 0", op_ready, res_valid); else pass_cnt++;
        issue(8'd100, 8'd100, 4'd0);
        @(negedge clk);
        total_cnt++; if (res_valid !== 1'b1 || res_data !== 16'd200 || op_count !== 16'd1)
            $display("FAIL mid_clean_op: got v=%0b d=%0d cnt=%0d want 1 200 1", res_valid, res_data, op_count); else pass_cnt++;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_settle3();
        total_cnt++; if (s3_op_ready !== 1'b1) $display("FAIL s3_ready: got %0b want 1", s3_op_ready); else pass_cnt++;
        s3_op_a = 8'd7; s3_op_b = 8'd8; s3_op_cmd = 4'd0; s3_op_valid = 1'b1;
        @(negedge clk);
        s3_op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (s3_alu_oe !== (i < 3) || s3_res_valid !== (i == 3) || s3_op_ready !== (i == 3))
                $display("FAIL s3_cycle_%0d: got oe=%0b v=%0b ready=%0b want %0b %0b %0b",
                         i, s3_alu_oe, s3_res_valid, s3_op_ready, (i < 3), (i == 3), (i == 3)); else pass_cnt++;
            if (i < 3) @(negedge clk);
        end
        total_cnt++; if (s3_res_data !== 16'd15 || s3_op_count !== 16'd1)
            $display("FAIL s3_result: got d=%0d cnt=%0d want 15 1", s3_res_data, s3_op_count); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst_n        = 1'b0;
        op_valid     = 1'b0;
        op_a         = 8'd0;
        op_b         = 8'd0;
        op_cmd       = 4'd0;
        res_ready    = 1'b0;
        s3_op_valid  = 1'b0;
        s3_op_a      = 8'd0;
        s3_op_b      = 8'd0;
        s3_op_cmd    = 4'd0;
        s3_res_ready = 1'b0;
        test_reset();
        test_add();
        test_mul_div();
        test_full();
        test_wrap_simul();
        test_reset_mid();
        test_settle3();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
